// File: rtl/vga_pkg.sv
// Shared VGA definitions.
//   - 640x480@60 raster timing constants and the derived line/frame totals
//   - rgb888_t: packed {R,G,B} pixel with named 8-bit fields
//   - vid_flags_t: per-pixel qualifiers carried alongside ROM read data
//   - cnt_width(): register width needed to count 0..total-1
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Qualifiers decoded from the raster counters; all-zero means
    // blank, outside image, sync inactive, no frame marker.
    typedef struct packed {
        logic active;
        logic in_img;
        logic hs;
        logic vs;
        logic frame;
    } vid_flags_t;

    function automatic int cnt_width(input int total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/vga_pixel_fetch_if.sv
// Bus between the pixel fetcher, the image ROM and the display pins.
//   addr        fetcher -> ROM   linear read address
//   rdata       ROM -> fetcher   registered {R,G,B} read data
//   red/green/blue, hsync, vsync, frame_start   fetcher -> display pins
// master: the fetcher side; slave: the ROM/display side.
interface vga_pixel_fetch_if;
    import vga_pkg::*;

    logic [23:0] addr;
    rgb888_t     rdata;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        hsync;
    logic        vsync;
    logic        frame_start;

    modport master (
        output addr, red, green, blue, hsync, vsync, frame_start,
        input  rdata
    );

    modport slave (
        input  addr, red, green, blue, hsync, vsync, frame_start,
        output rdata
    );

endinterface

// File: rtl/vga_timing.sv
// Raster counters and stage-0 timing decode, reusable by any display source.
//   clk, rst        pixel clock, synchronous active-high reset
//   h_cnt, v_cnt    current raster position
//   h_last, v_last  position is the last pixel of a line / last line of a frame
//   active          position is inside the visible area
//   hs, vs          position is inside the horizontal / vertical sync pulse
//   frame           position is (0,0)
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = cnt_width(H_TOTAL),
    localparam int VW      = cnt_width(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          h_last,
    output logic          v_last,
    output logic          active,
    output logic          hs,
    output logic          vs,
    output logic          frame
);

    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    assign h_last = (h_cnt == HW'(H_TOTAL - 1));
    assign v_last = (v_cnt == VW'(V_TOTAL - 1));

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    always_comb begin
        active = 1'b0;
        hs     = 1'b0;
        vs     = 1'b0;
        frame  = 1'b0;
        if (h_cnt < HW'(H_ACTIVE) && v_cnt < VW'(V_ACTIVE)) active = 1'b1;
        if (h_cnt >= HW'(HS_START) && h_cnt < HW'(HS_END)) hs = 1'b1;
        if (v_cnt >= VW'(VS_START) && v_cnt < VW'(VS_END)) vs = 1'b1;
        if (h_cnt == '0 && v_cnt == '0) frame = 1'b1;
    end

endmodule

// File: rtl/vga_pixel_fetch.sv
// VGA pixel fetcher: raster timing, linear image-ROM addressing, and
// delay-matched RGB/sync output registers.
//   clk, rst   pixel clock, synchronous active-high reset
//   bus        master side of vga_pixel_fetch_if:
//                addr out, rdata in (ROM_LAT cycles after addr),
//                red/green/blue, hsync, vsync, frame_start out
// The image sits at the screen origin; visible pixels outside it show
// BORDER_RGB. Pins show raster position (h,v) ROM_LAT+1 cycles after the
// counters held it.
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter int          H_ACTIVE   = VGA_H_ACTIVE,
    parameter int          H_FP       = VGA_H_FP,
    parameter int          H_SYNC     = VGA_H_SYNC,
    parameter int          H_BP       = VGA_H_BP,
    parameter int          V_ACTIVE   = VGA_V_ACTIVE,
    parameter int          V_FP       = VGA_V_FP,
    parameter int          V_SYNC     = VGA_V_SYNC,
    parameter int          V_BP       = VGA_V_BP,
    parameter logic        SYNC_POL   = 1'b0,
    parameter int          IMG_W      = 160,
    parameter int          IMG_H      = 120,
    parameter int          ROM_LAT    = 1,
    parameter logic [23:0] BORDER_RGB = 24'h000000
) (
    input  logic                clk,
    input  logic                rst,
    vga_pixel_fetch_if.master   bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = cnt_width(H_TOTAL);
    localparam int VW      = cnt_width(V_TOTAL);

    if (IMG_W > H_ACTIVE) begin : g_chk_img_w
        $error("IMG_W must not exceed H_ACTIVE");
    end
    if (IMG_H > V_ACTIVE) begin : g_chk_img_h
        $error("IMG_H must not exceed V_ACTIVE");
    end
    if (ROM_LAT < 1) begin : g_chk_lat
        $error("ROM_LAT must be at least 1");
    end
    if (longint'(IMG_W) * longint'(IMG_H) > 64'd16777216) begin : g_chk_size
        $error("IMG_W*IMG_H must fit a 24-bit address");
    end

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_last;
    logic          v_last;
    logic          active;
    logic          hs;
    logic          vs;
    logic          frame;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk    (clk),
        .rst    (rst),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .h_last (h_last),
        .v_last (v_last),
        .active (active),
        .hs     (hs),
        .vs     (vs),
        .frame  (frame)
    );

    logic in_img;
    assign in_img = (h_cnt < HW'(IMG_W)) && (v_cnt < VW'(IMG_H));

    // row_base tracks v*IMG_W by accumulation, so no multiplier is needed.
    // It stops advancing on the last image line and is cleared at frame end.
    logic [23:0] row_base;

    always_ff @(posedge clk) begin
        if (rst) begin
            row_base <= '0;
        end else if (h_last) begin
            if (v_last) begin
                row_base <= '0;
            end else if (v_cnt < VW'(IMG_H - 1)) begin
                row_base <= row_base + 24'(IMG_W);
            end
        end
    end

    assign bus.addr = in_img ? row_base + 24'(h_cnt) : '0;

    // Qualifiers travel ROM_LAT stages so they line up with rdata.
    vid_flags_t cur_flags;
    vid_flags_t dly [ROM_LAT];
    vid_flags_t out_flags;

    always_comb begin
        cur_flags        = '0;
        cur_flags.active = active;
        cur_flags.in_img = in_img;
        cur_flags.hs     = hs;
        cur_flags.vs     = vs;
        cur_flags.frame  = frame;
    end

    // NOTE: this short delay line is reset, unlike a bulk memory, because it
    // carries the blanking and sync qualifiers that must go inactive on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROM_LAT; i++) dly[i] <= '0;
        end else begin
            dly[0] <= cur_flags;
            for (int i = 1; i < ROM_LAT; i++) dly[i] <= dly[i-1];
        end
    end

    assign out_flags = dly[ROM_LAT-1];

    rgb888_t rgb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q           <= '0;
            bus.hsync       <= ~SYNC_POL;
            bus.vsync       <= ~SYNC_POL;
            bus.frame_start <= 1'b0;
        end else begin
            if (!out_flags.active) begin
                rgb_q <= '0;
            end else if (out_flags.in_img) begin
                rgb_q <= bus.rdata;
            end else begin
                rgb_q <= rgb888_t'(BORDER_RGB);
            end
            bus.hsync       <= out_flags.hs ? SYNC_POL : ~SYNC_POL;
            bus.vsync       <= out_flags.vs ? SYNC_POL : ~SYNC_POL;
            bus.frame_start <= out_flags.frame;
        end
    end

    assign bus.red   = rgb_q.r;
    assign bus.green = rgb_q.g;
    assign bus.blue  = rgb_q.b;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Scoreboard bench for vga_pixel_fetch.
//   dut 0: full 640x480 timing, 160x120 image, ROM_LAT=1, ROM word = address
//   dut 1: reduced 56x37 raster, 16x12 image, ROM_LAT=2, random ROM words
// A reference model walks the raster with plain arithmetic and queues the
// expected pin values; a monitor pops one entry per cycle and compares.
module tb_vga_pixel_fetch;
    import vga_pkg::*;

    localparam logic [23:0] BORDER = 24'h123456;

    localparam int HA [2] = '{640, 40};
    localparam int HFP[2] = '{16, 4};
    localparam int HSW[2] = '{96, 6};
    localparam int HBP[2] = '{48, 6};
    localparam int VA [2] = '{480, 30};
    localparam int VFP[2] = '{10, 2};
    localparam int VSW[2] = '{2, 2};
    localparam int VBP[2] = '{33, 3};
    localparam int IW [2] = '{160, 16};
    localparam int IH [2] = '{120, 12};
    localparam int LAT[2] = '{1, 2};

    typedef struct {
        bit          is_rst;
        int          h;
        int          v;
        logic [23:0] rgb;
        logic        hsync;
        logic        vsync;
        logic        fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    initial forever #5 clk = ~clk;

    vga_pixel_fetch_if bus_a ();
    vga_pixel_fetch_if bus_b ();

    vga_pixel_fetch #(
        .H_ACTIVE(HA[0]), .H_FP(HFP[0]), .H_SYNC(HSW[0]), .H_BP(HBP[0]),
        .V_ACTIVE(VA[0]), .V_FP(VFP[0]), .V_SYNC(VSW[0]), .V_BP(VBP[0]),
        .SYNC_POL(1'b0), .IMG_W(IW[0]), .IMG_H(IH[0]), .ROM_LAT(LAT[0]),
        .BORDER_RGB(BORDER)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    vga_pixel_fetch #(
        .H_ACTIVE(HA[1]), .H_FP(HFP[1]), .H_SYNC(HSW[1]), .H_BP(HBP[1]),
        .V_ACTIVE(VA[1]), .V_FP(VFP[1]), .V_SYNC(VSW[1]), .V_BP(VBP[1]),
        .SYNC_POL(1'b0), .IMG_W(IW[1]), .IMG_H(IH[1]), .ROM_LAT(LAT[1]),
        .BORDER_RGB(BORDER)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // ---------------- ROM models ----------------
    logic [23:0] rom0 [19200];
    logic [23:0] rom1 [192];
    logic [23:0] rdata_a = '0;
    logic [23:0] rb1     = '0;
    logic [23:0] rdata_b = '0;

    function automatic logic [23:0] rom_word(input int d, input int idx);
        if (d == 0) return (idx >= 0 && idx < 19200) ? rom0[idx] : 24'h0;
        return (idx >= 0 && idx < 192) ? rom1[idx] : 24'h0;
    endfunction

    initial forever begin
        @(posedge clk);
        rdata_a <= rom_word(0, int'(bus_a.addr));
        rb1     <= rom_word(1, int'(bus_b.addr));
        rdata_b <= rb1;
    end

    assign bus_a.rdata = rdata_a;
    assign bus_b.rdata = rdata_b;

    // ---------------- pin taps ----------------
    logic [23:0] addr_w [2];
    logic [23:0] rgb_w  [2];
    logic        hs_w   [2];
    logic        vs_w   [2];
    logic        fs_w   [2];

    assign addr_w[0] = bus_a.addr;
    assign addr_w[1] = bus_b.addr;
    assign rgb_w[0]  = {bus_a.red, bus_a.green, bus_a.blue};
    assign rgb_w[1]  = {bus_b.red, bus_b.green, bus_b.blue};
    assign hs_w[0]   = bus_a.hsync;
    assign hs_w[1]   = bus_b.hsync;
    assign vs_w[0]   = bus_a.vsync;
    assign vs_w[1]   = bus_b.vsync;
    assign fs_w[0]   = bus_a.frame_start;
    assign fs_w[1]   = bus_b.frame_start;

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;
    bit [9:0] spot_seen = '0;

    task automatic check(input string what, input int d, input int h, input int v,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d at (%0d,%0d): got 0x%0h, expected 0x%0h",
                     what, d, h, v, act, exp);
        end
    endtask

    function automatic int h_total(input int d);
        return HA[d] + HFP[d] + HSW[d] + HBP[d];
    endfunction

    function automatic int v_total(input int d);
        return VA[d] + VFP[d] + VSW[d] + VBP[d];
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e.is_rst = 1'b1; e.h = -1; e.v = -1;
        e.rgb = 24'h0; e.hsync = 1'b1; e.vsync = 1'b1; e.fs = 1'b0;
        return e;
    endfunction

    function automatic exp_t pixel_exp(input int d, input int h, input int v);
        exp_t e;
        bit act, img;
        act = (h < HA[d]) && (v < VA[d]);
        img = (h < IW[d]) && (v < IH[d]);
        e.is_rst = 1'b0; e.h = h; e.v = v;
        if (!act)     e.rgb = 24'h0;
        else if (img) e.rgb = rom_word(d, v * IW[d] + h);
        else          e.rgb = BORDER;
        e.hsync = (h >= HA[d] + HFP[d] && h < HA[d] + HFP[d] + HSW[d]) ? 1'b0 : 1'b1;
        e.vsync = (v >= VA[d] + VFP[d] && v < VA[d] + VFP[d] + VSW[d]) ? 1'b0 : 1'b1;
        e.fs    = (h == 0 && v == 0);
        return e;
    endfunction

    function automatic logic [23:0] addr_exp(input int d, input int h, input int v);
        if (h < IW[d] && v < IH[d]) return 24'(v * IW[d] + h);
        return 24'h0;
    endfunction

    // ---------------- reference model ----------------
    exp_t        q0 [$];
    exp_t        q1 [$];
    int          mh [2] = '{0, 0};
    int          mv [2] = '{0, 0};
    bit          armed [2] = '{1'b0, 1'b0};
    bit          rst_seen = 1'b0;
    logic [23:0] exp_addr [2];

    task automatic push_exp(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        rst_seen = rst;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                armed[d] = 1'b1;
                if (d == 0) q0.delete();
                else        q1.delete();
                // Pins hold reset values for LAT+1 cycles; then this
                // cycle's (0,0) emerges.
                for (int i = 0; i <= LAT[d]; i++) push_exp(d, reset_exp());
                mh[d] = 0;
                mv[d] = 0;
            end else if (armed[d]) begin
                mh[d]++;
                if (mh[d] == h_total(d)) begin
                    mh[d] = 0;
                    mv[d]++;
                    if (mv[d] == v_total(d)) mv[d] = 0;
                end
            end
            if (armed[d]) begin
                push_exp(d, pixel_exp(d, mh[d], mv[d]));
                exp_addr[d] = addr_exp(d, mh[d], mv[d]);
            end
        end
    end

    // ---------------- monitor ----------------
    int cyc = 0;
    int last_hf [2] = '{-1, -1};
    int last_vf [2] = '{-1, -1};
    int last_fs [2] = '{-1, -1};
    bit prev_h  [2] = '{1'b1, 1'b1};
    bit prev_v  [2] = '{1'b1, 1'b1};

    initial forever begin
        @(negedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            bit   have;
            if (armed[d]) begin
                check("addr", d, mh[d], mv[d], 32'(addr_w[d]), 32'(exp_addr[d]));
                if (d == 0 && mh[d] == 5 && mv[d] == 2) begin
                    spot_seen[0] = 1'b1; check("addr spot", d, 5, 2, 32'(addr_w[d]), 32'd325);
                end
                if (d == 0 && mh[d] == 160 && mv[d] == 0) begin
                    spot_seen[1] = 1'b1; check("addr spot", d, 160, 0, 32'(addr_w[d]), 32'd0);
                end
                if (d == 1 && mh[d] == 15 && mv[d] == 11) begin
                    spot_seen[6] = 1'b1; check("addr spot", d, 15, 11, 32'(addr_w[d]), 32'd191);
                end
                if (d == 1 && mh[d] == 0 && mv[d] == 12) begin
                    spot_seen[7] = 1'b1; check("addr spot", d, 0, 12, 32'(addr_w[d]), 32'd0);
                end
            end

            have = 1'b0;
            if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            if (have) begin
                check("rgb", d, e.h, e.v, 32'(rgb_w[d]), 32'(e.rgb));
                check("hsync", d, e.h, e.v, 32'(hs_w[d]), 32'(e.hsync));
                check("vsync", d, e.h, e.v, 32'(vs_w[d]), 32'(e.vsync));
                check("frame_start", d, e.h, e.v, 32'(fs_w[d]), 32'(e.fs));
                if (!e.is_rst) begin
                    if (d == 0 && e.h == 5 && e.v == 0) begin
                        spot_seen[2] = 1'b1; check("pix spot", d, 5, 0, 32'(rgb_w[d]), 32'h000005);
                    end
                    if (d == 0 && e.h == 200 && e.v == 10) begin
                        spot_seen[3] = 1'b1; check("pix spot", d, 200, 10, 32'(rgb_w[d]), 32'h123456);
                    end
                    if (d == 0 && e.h == 700 && e.v == 10) begin
                        spot_seen[4] = 1'b1; check("pix spot", d, 700, 10, 32'(rgb_w[d]), 32'h0);
                    end
                    if (d == 0 && e.h == 656 && e.v == 0) begin
                        spot_seen[5] = 1'b1; check("hsync spot", d, 656, 0, 32'(hs_w[d]), 32'h0);
                    end
                    if (d == 1 && e.h == 16 && e.v == 3) begin
                        spot_seen[8] = 1'b1; check("pix spot", d, 16, 3, 32'(rgb_w[d]), 32'h123456);
                    end
                    if (d == 1 && e.h == 3 && e.v == 31) begin
                        spot_seen[9] = 1'b1; check("pix spot", d, 3, 31, 32'(rgb_w[d]), 32'h0);
                    end
                end
            end

            // Sync pulse widths and periods; a reset abandons the current measurement.
            if (rst_seen) begin
                last_hf[d] = -1;
                last_vf[d] = -1;
                last_fs[d] = -1;
            end
            if (prev_h[d] && !hs_w[d]) begin
                if (last_hf[d] >= 0) check("hsync period", d, -1, -1, 32'(cyc - last_hf[d]), 32'(h_total(d)));
                last_hf[d] = cyc;
            end
            if (!prev_h[d] && hs_w[d] && last_hf[d] >= 0)
                check("hsync width", d, -1, -1, 32'(cyc - last_hf[d]), 32'(HSW[d]));
            if (prev_v[d] && !vs_w[d]) begin
                if (last_vf[d] >= 0)
                    check("vsync period", d, -1, -1, 32'(cyc - last_vf[d]), 32'(h_total(d) * v_total(d)));
                last_vf[d] = cyc;
            end
            if (!prev_v[d] && vs_w[d] && last_vf[d] >= 0)
                check("vsync width", d, -1, -1, 32'(cyc - last_vf[d]), 32'(VSW[d] * h_total(d)));
            if (fs_w[d] === 1'b1) begin
                if (last_fs[d] >= 0)
                    check("frame period", d, -1, -1, 32'(cyc - last_fs[d]), 32'(h_total(d) * v_total(d)));
                last_fs[d] = cyc;
            end
            prev_h[d] = hs_w[d];
            prev_v[d] = vs_w[d];
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 19200; i++) rom0[i] = 24'(i);
        for (int i = 0; i < 192; i++)   rom1[i] = 24'($urandom);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10000) @(negedge clk);

        // Three-cycle reset in the middle of a line.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2500) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(2500, 40)) @(negedge clk);
            rst = 1'b1;
            repeat ($urandom_range(3, 1)) @(negedge clk);
            rst = 1'b0;
        end

        // Long undisturbed run for frame-level periods on the reduced raster.
        repeat (7000) @(negedge clk);

        for (int i = 0; i < 10; i++)
            check("spot coverage", -1, i, -1, 32'(spot_seen[i]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
- Upstream neighbour of the VGA image ROM: generates VGA raster timing and the linear ROM read address for each pixel.
- Consumes the ROM's registered 24-bit read data and drives delay-matched RGB 8:8:8, hsync and vsync to the display pins.
- The image is placed at screen origin; active pixels outside the image show a border colour.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync
- IMG_W, 160, stored image width (pixels)
- IMG_H, 120, stored image height (lines)
- ROM_LAT, 1, ROM read latency in clk cycles
- BORDER_RGB, 24'h000000, colour for active pixels outside the image

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- addr  out  24  ROM read address
- rdata  in  24  ROM read data, {R,G,B}, valid ROM_LAT cycles after addr
- red  out  8  pixel red
- green  out  8  pixel green
- blue  out  8  pixel blue
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- frame_start  out  1  one-cycle pulse, aligned with output of pixel (0,0)

Behaviour:
- One clock (clk); reset is synchronous and active-high on rst. All state updates on posedge clk.
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters (800). It wraps to 0.
  - v_cnt runs 0..V_TOTAL-1, where V_TOTAL = 525. It increments when h_cnt wraps and itself wraps to 0.
- Stage-0 flags, decoded from the counters:
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
  - in_img = h_cnt<IMG_W && v_cnt<IMG_H
  - hs = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751
  - vs = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491
- Address generation (no multiplier):
  - row_base register; addr = row_base + h_cnt when in_img, else 0.
  - At h_cnt==H_TOTAL-1: if v_cnt==V_TOTAL-1, row_base <= 0; else if v_cnt<IMG_H-1, row_base <= row_base+IMG_W; else hold.
  - Net effect: addr = v*IMG_W + h inside the image.
- Delay matching: active, in_img, hs, vs and the frame flag (h_cnt==0 && v_cnt==0) pass through a ROM_LAT-deep shift register, so they align with rdata.
- Output register stage:
  - if !active_d: rgb = 0
  - else if in_img_d: rgb = rdata
  - else: rgb = BORDER_RGB
  - hsync = hs_d ? SYNC_POL : !SYNC_POL; vsync likewise.
  - frame_start = frame_d.
- Latency: pins reflect counter position (h,v) exactly ROM_LAT+1 cycles after the counters held (h,v).
- Reset values (effective the cycle after rst is sampled high):
  - h_cnt, v_cnt, row_base = 0; addr = 0
  - all delay stages cleared to blank / inactive sync / no frame
  - red, green, blue = 0; hsync, vsync = !SYNC_POL; frame_start = 0
- Reset mid-frame: same values; the raster restarts at (0,0) on the first cycle after rst deasserts.
- Widths: counters are sized from H_TOTAL/V_TOTAL. row_base and addr are 24 bits; IMG_W*IMG_H must be ≤ 2^24 (elaboration check).
- Elaboration checks: IMG_W ≤ H_ACTIVE, IMG_H ≤ V_ACTIVE, ROM_LAT ≥ 1.

Decomposition:
- Shared package vga_pkg:
  - 640x480@60 timing constants and derived H_TOTAL/V_TOTAL
  - rgb888 typedef with R/G/B field slices
  - counter-width function (clog2-based)
- One natural sub-module, vga_timing: h/v counters plus active/hs/vs/frame decode. It is reusable by other display sources.
- vga_pixel_fetch adds address generation, delay matching and output muxing.

Test Plan:
- Reset: hold rst 3 cycles mid-frame → next cycle red/green/blue=0, hsync=vsync=1 (SYNC_POL=0), frame_start=0, addr=0; h_cnt=0 on first post-reset cycle.
- First pixel: ROM model returns rdata = addr one cycle later; release rst → frame_start=1 and rgb=0x000000 on the 2nd cycle after release; the pixel at counter (5,0) shows rgb=0x000005 two cycles later.
- Address raster: check addr=325 at counter (5,2); addr=19199 at (159,119); addr=0 at (160,0) and at (0,120).
- Border/blank: BORDER_RGB=0x123456 → pixel (200,10) outputs 0x123456; pixel (700,10) and any line ≥480 output 0.
- Sync timing: hsync low for exactly 96 cycles starting at output of h=656; vsync low for exactly 2 lines starting at line 490; period 800 cycles/line and 420000 cycles/frame; frame_start once per frame.
- ROM_LAT=2 with a 2-stage ROM model: same image checks pass with pin latency 3; no pixel is misaligned at image edges (h=159→160).
